// File: rtl/out_port_pkg.sv
// Shared constants and FSM encoding for the router output port.
package out_port_pkg;
  localparam int PORT_W = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_N = 3;
  localparam int PORT_L = 4;
  localparam int N_PORTS = 5;
  localparam int TAIL_BIT = 4;
  localparam int DEST_MSB = 3;
  localparam int DEST_LSB = 0;
  localparam int DATA_WIDTH_DEF = 37;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    REQ,
    RELEASE
  } state_e;
endpackage

// File: rtl/noc_xy_route.sv
// XY dimension-order route selection: X first, then Y, else local.
module noc_xy_route
  import out_port_pkg::*;
#(
  parameter logic [3:0] POSITION = 4'b0101
) (
  input  logic [3:0] dest,
  output logic [2:0] port
);
  localparam logic [1:0] OWN_X = POSITION[3:2];
  localparam logic [1:0] OWN_Y = POSITION[1:0];

  logic [1:0] dx;
  logic [1:0] dy;

  assign dx = dest[3:2];
  assign dy = dest[1:0];

  always_comb begin
    port = 3'(PORT_L);
    unique case (1'b1)
      (dx > OWN_X): port = 3'(PORT_E);
      (dx < OWN_X): port = 3'(PORT_W);
      (dx == OWN_X && dy > OWN_Y): port = 3'(PORT_N);
      (dx == OWN_X && dy < OWN_Y): port = 3'(PORT_S);
      default: port = 3'(PORT_L);
    endcase
  end
endmodule

// File: rtl/out_port.sv
// Router output port: pulls flits from the FIFO and hands them to the
// XY-selected neighbour with a four-phase req/ack, wormhole-locked.
module out_port
  import out_port_pkg::*;
#(
  parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [3:0] POSITION   = 4'b0101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  rdreq,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  Outr_L,
  output logic                  Outr_N,
  output logic                  Outr_E,
  output logic                  Outr_S,
  output logic                  Outr_W,
  input  logic                  Outw_L,
  input  logic                  Outw_N,
  input  logic                  Outw_E,
  input  logic                  Outw_S,
  input  logic                  Outw_W
);
  state_e                  state_q, state_d;
  logic                    rdreq_q, rdreq_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [N_PORTS-1:0]      outr_q, outr_d;
  logic [2:0]              route_q, route_d;
  logic                    lock_q, lock_d;

  logic [2:0]              xy_port;
  logic [2:0]              sel_route;
  logic [N_PORTS-1:0]      outw;
  logic [N_PORTS-1:0]      route_oh;
  logic                    ack;

  noc_xy_route #(
    .POSITION(POSITION)
  ) u_route (
    .dest(q[DEST_MSB:DEST_LSB]),
    .port(xy_port)
  );

  assign outw = {Outw_L, Outw_N, Outw_E, Outw_S, Outw_W};
  assign route_oh = N_PORTS'(1) << route_q;
  // Only the locked direction's ack is observed.
  assign ack = |(outw & route_oh);
  assign sel_route = lock_q ? route_q : xy_port;

  always_comb begin
    state_d = state_q;
    rdreq_d = 1'b0;
    data_d  = data_q;
    outr_d  = outr_q;
    route_d = route_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        if (rdreq_q) begin
          state_d = FETCH;
        end else if (!empty) begin
          rdreq_d = 1'b1;
        end
      end
      FETCH: begin
        data_d  = q;
        route_d = sel_route;
        lock_d  = 1'b1;
        outr_d  = N_PORTS'(1) << sel_route;
        state_d = REQ;
      end
      REQ: begin
        if (ack) begin
          outr_d  = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack) begin
          if (data_q[TAIL_BIT]) lock_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdreq_q <= 1'b0;
      data_q  <= '0;
      outr_q  <= '0;
      route_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdreq_q <= rdreq_d;
      data_q  <= data_d;
      outr_q  <= outr_d;
      route_q <= route_d;
      lock_q  <= lock_d;
    end
  end

  assign rdreq   = rdreq_q;
  assign dataOut = data_q;
  assign Outr_W  = outr_q[PORT_W];
  assign Outr_S  = outr_q[PORT_S];
  assign Outr_E  = outr_q[PORT_E];
  assign Outr_N  = outr_q[PORT_N];
  assign Outr_L  = outr_q[PORT_L];
endmodule

// File: tb/tb_out_port.sv
// Scoreboard bench for out_port: FIFO and neighbour-ack models,
// monitor pops expected {direction, flit} on every request rise.
module tb_out_port;
  localparam int DW = 37;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          empty;
  logic [DW-1:0] q = '0;
  logic          rdreq;
  logic [DW-1:0] dataOut;
  logic          Outr_L, Outr_N, Outr_E, Outr_S, Outr_W;
  logic          Outw_L, Outw_N, Outw_E, Outw_S, Outw_W;

  logic [4:0] outr;
  logic [4:0] outw;
  logic [4:0] ack_q = '0;
  logic [4:0] ack_en = 5'b11111;
  logic [4:0] force_w = '0;

  logic [DW-1:0]   fifo[$];
  logic [DW+4:0]   exp_q[$];
  int push_cnt = 0;
  int pop_cnt = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cyc = -100;
  int rd_count = 0;
  logic [4:0]    prev_outr = '0;
  logic [DW-1:0] held = '0;

  localparam logic [4:0] D_W = 5'b00001;
  localparam logic [4:0] D_S = 5'b00010;
  localparam logic [4:0] D_E = 5'b00100;
  localparam logic [4:0] D_N = 5'b01000;
  localparam logic [4:0] D_L = 5'b10000;

  always #5 clk = ~clk;

  out_port dut (
    .clk(clk), .reset(reset), .empty(empty), .q(q),
    .rdreq(rdreq), .dataOut(dataOut),
    .Outr_L(Outr_L), .Outr_N(Outr_N), .Outr_E(Outr_E),
    .Outr_S(Outr_S), .Outr_W(Outr_W),
    .Outw_L(Outw_L), .Outw_N(Outw_N), .Outw_E(Outw_E),
    .Outw_S(Outw_S), .Outw_W(Outw_W)
  );

  assign outr = {Outr_L, Outr_N, Outr_E, Outr_S, Outr_W};
  assign outw = ack_q | force_w;
  assign {Outw_L, Outw_N, Outw_E, Outw_S, Outw_W} = outw;
  assign empty = (push_cnt == pop_cnt);

  // Normal-mode FIFO: data appears the cycle after rdreq.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo.delete();
      pop_cnt <= push_cnt;
    end else if (rdreq && fifo.size() != 0) begin
      q <= fifo.pop_front();
      pop_cnt <= pop_cnt + 1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) ack_q <= '0;
    else       ack_q <= outr & ack_en;
  end

  always @(negedge clk) begin
    logic [DW+4:0] e;
    cyc = cyc + 1;
    if (rdreq) begin
      rd_cyc = cyc;
      rd_count = rd_count + 1;
    end
    if (!$onehot0(outr)) begin
      errors = errors + 1;
      $display("FAIL onehot outr=%b", outr);
    end
    if (outr != 0 && prev_outr == 0) begin
      held = dataOut;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_req got dir=%b data=%h", outr, dataOut);
      end else begin
        e = exp_q.pop_front();
        if (outr != e[DW+4:DW] || dataOut != e[DW-1:0]) begin
          errors = errors + 1;
          $display("FAIL flit got dir=%b data=%h want dir=%b data=%h",
                   outr, dataOut, e[DW+4:DW], e[DW-1:0]);
        end
      end
      checks = checks + 1;
      if (cyc - rd_cyc != 2) begin
        errors = errors + 1;
        $display("FAIL req_latency got %0d want 2", cyc - rd_cyc);
      end
    end else if (outr != 0 && dataOut != held) begin
      errors = errors + 1;
      $display("FAIL data_stable got %h want %h", dataOut, held);
    end
    prev_outr = outr;
  end

  task automatic send(input logic [3:0] dest, input logic tail,
                      input logic [31:0] pay, input logic [4:0] dir,
                      input bit expect_it);
    logic [DW-1:0] f;
    f = {pay, tail, dest};
    fifo.push_back(f);
    push_cnt = push_cnt + 1;
    if (expect_it) exp_q.push_back({dir, f});
  endtask

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && empty && outr == 0 && outw == 0)
           && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    checks = checks + 1;
    if (n >= 300) begin
      errors = errors + 1;
      $display("FAIL %s drain timeout pending=%0d", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_req(input logic [4:0] dir, input string name);
    int n;
    n = 0;
    while (outr != dir && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    checks = checks + 1;
    if (n >= 100) begin
      errors = errors + 1;
      $display("FAIL %s wait got outr=%b want %b", name, outr, dir);
    end
  endtask

  initial begin
    int bad;
    logic [DW-1:0] snap;

    repeat (3) @(negedge clk);
    check("reset_rdreq", DW'(rdreq), DW'(0));
    check("reset_data", dataOut, '0);
    check("reset_outr", DW'(outr), DW'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single tail flit heading east, then no extra reads.
    rd_count = 0;
    send(4'b1001, 1'b1, 32'hA5A5_0001, D_E, 1'b1);
    drain("single_e");
    repeat (10) @(negedge clk);
    check("single_reads", DW'(rd_count), DW'(1));

    send(4'b0101, 1'b1, 32'h0000_0002, D_L, 1'b1);
    drain("dir_l");
    send(4'b0001, 1'b1, 32'h0000_0003, D_W, 1'b1);
    drain("dir_w");
    send(4'b0111, 1'b1, 32'h0000_0004, D_N, 1'b1);
    drain("dir_n");
    send(4'b0100, 1'b1, 32'h0000_0005, D_S, 1'b1);
    drain("dir_s");

    // Wormhole: body/tail dest bits ignored; lock released after tail.
    rd_count = 0;
    send(4'b0100, 1'b0, 32'h1111_0000, D_S, 1'b1);
    send(4'b1111, 1'b0, 32'h1111_0001, D_S, 1'b1);
    send(4'b1111, 1'b1, 32'h1111_0002, D_S, 1'b1);
    send(4'b1111, 1'b1, 32'h2222_0000, D_E, 1'b1);
    drain("packet3");
    check("packet3_reads", DW'(rd_count), DW'(4));

    // Ack stall on S for 20 cycles.
    ack_en = 5'b11101;
    send(4'b0100, 1'b1, 32'h3333_0000, D_S, 1'b1);
    wait_req(D_S, "stall");
    snap = dataOut;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!Outr_S || dataOut != snap || rdreq) bad = bad + 1;
    end
    check("stall_hold", DW'(bad), DW'(0));
    check("stall_data", dataOut, {32'h3333_0000, 1'b1, 4'b0100});
    ack_en = 5'b11111;
    drain("stall");

    // Async reset while requesting east mid-packet.
    ack_en = 5'b11011;
    send(4'b1001, 1'b0, 32'h4444_0000, D_E, 1'b1);
    send(4'b1001, 1'b1, 32'h4444_0001, D_E, 1'b0);
    wait_req(D_E, "rst_mid");
    #2;
    reset = 1'b1;
    #1;
    check("rst_outr", DW'(outr), DW'(0));
    check("rst_data", dataOut, '0);
    check("rst_rdreq", DW'(rdreq), DW'(0));
    @(negedge clk);
    reset = 1'b0;
    ack_en = 5'b11111;
    send(4'b0001, 1'b1, 32'h5555_0000, D_W, 1'b1);
    drain("rst_after");

    // Stray ack on N while routing east.
    ack_en = 5'b11011;
    send(4'b1001, 1'b1, 32'h6666_0000, D_E, 1'b1);
    wait_req(D_E, "stray");
    force_w = 5'b01000;
    @(negedge clk);
    force_w = 5'b00000;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!Outr_E || Outr_N || rdreq) bad = bad + 1;
    end
    check("stray_ack", DW'(bad), DW'(0));
    ack_en = 5'b11111;
    drain("stray");

    check("fifo_consumed", DW'(push_cnt - pop_cnt), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
